// File: rtl/ps2_host_sender.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte (LSB first, odd parity, stop) on device clock edges.
`timescale 1ns/1ps
module ps2_host_sender #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, WAIT_START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [19:0]      START_LAST = 20'(START_TIMEOUT - 1);
  localparam logic [16:0]      XFER_LAST  = 17'(XFER_TIMEOUT - 1);

  state_t           state;
  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_prev;
  logic             clk_s;
  logic             dat_s;
  logic             fe;
  logic [7:0]       shift;
  logic             parity;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [19:0]      start_timer;
  logic [16:0]      xfer_timer;

  // Sync regs reset high so an idle bus never produces a spurious edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s     = clk_sync[1];
  assign dat_s     = dat_sync[1];
  assign fe        = clk_prev & ~clk_s;
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_dat_oe  <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ack_ok      <= 1'b0;
      shift       <= 8'd0;
      parity      <= 1'b0;
      bit_cnt     <= 4'd0;
      inh_cnt     <= '0;
      start_timer <= 20'd0;
      xfer_timer  <= 17'd0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (cmd_valid) begin
            shift      <= cmd_data;
            parity     <= ~^cmd_data;
            ack_ok     <= 1'b0;
            bit_cnt    <= 4'd0;
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_dat_oe <= 1'b1;
            state      <= REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        REQ: begin
          ps2_clk_oe  <= 1'b0;
          start_timer <= 20'd0;
          state       <= WAIT_START;
        end
        WAIT_START: begin
          if (fe) begin
            ps2_dat_oe <= ~shift[0];
            shift      <= {1'b0, shift[7:1]};
            bit_cnt    <= 4'd1;
            xfer_timer <= 17'd0;
            state      <= DATA;
          end else if (start_timer == START_LAST) begin
            start_timer <= start_timer + 20'd1;
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            error       <= 1'b1;
            state       <= IDLE;
          end else begin
            start_timer <= start_timer + 20'd1;
          end
        end
        DATA, PARITY, STOP, WAIT_IDLE: begin
          // The transfer timeout overrides any edge or idle seen in the same cycle.
          if (xfer_timer == XFER_LAST) begin
            xfer_timer <= xfer_timer + 17'd1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            error      <= 1'b1;
            state      <= IDLE;
          end else begin
            xfer_timer <= xfer_timer + 17'd1;
            if (state == WAIT_IDLE) begin
              if (clk_s && dat_s) begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end else if (fe) begin
              case (state)
                DATA: begin
                  if (bit_cnt == 4'd8) begin
                    ps2_dat_oe <= ~parity;
                    state      <= PARITY;
                  end else begin
                    ps2_dat_oe <= ~shift[0];
                    shift      <= {1'b0, shift[7:1]};
                    bit_cnt    <= bit_cnt + 4'd1;
                  end
                end
                PARITY: begin
                  ps2_dat_oe <= 1'b0;
                  state      <= STOP;
                end
                default: begin
                  ack_ok <= ~dat_s;
                  state  <= WAIT_IDLE;
                end
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
